// File: rtl/packet_stream_gen.sv
// Command-driven packet source: one header/len/seed command becomes a start/last framed
// stream whose payload words count up from the seed.
module packet_stream_gen_lane #(
    parameter int IDX = 0
) (
    input  logic        en,
    input  logic [31:0] base,
    output logic [31:0] word
);
    assign word = en ? base + 32'(IDX) : '0;
endmodule

module packet_stream_gen #(
    parameter int HEADER_BUS_WIDTH  = 512,
    parameter int PAYLOAD_BUS_WIDTH = 512,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_cmd_valid,
    input  logic [HEADER_BUS_WIDTH-1:0]  iv_cmd_head,
    input  logic [LEN_WIDTH-1:0]         iv_cmd_len,
    input  logic [31:0]                  iv_cmd_seed,
    output logic                         o_cmd_ready,
    output logic                         o_packet_out_valid,
    output logic [HEADER_BUS_WIDTH-1:0]  ov_packet_out_head,
    output logic [PAYLOAD_BUS_WIDTH-1:0] ov_packet_out_data,
    output logic                         o_packet_out_start,
    output logic                         o_packet_out_last,
    input  logic                         i_packet_out_ready,
    output logic                         o_busy,
    output logic [31:0]                  ov_pkt_cnt
);
    localparam int WORDS = PAYLOAD_BUS_WIDTH / 32;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [HEADER_BUS_WIDTH-1:0] head;
        logic [LEN_WIDTH-1:0]        len;
        logic [31:0]                 seed;
    } cmd_t;

    state_t               state, state_nxt;
    cmd_t                 cmd_r;
    logic [LEN_WIDTH-1:0] k;
    logic [31:0]          pkt_cnt;
    logic                 cmd_fire, beat_fire, at_last;
    logic [31:0]          base;
    logic [WORDS-1:0][31:0] words;

    assign at_last   = (k == cmd_r.len - LEN_WIDTH'(1));
    assign cmd_fire  = o_cmd_ready & i_cmd_valid;
    assign beat_fire = o_packet_out_valid & i_packet_out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd_r   <= '0;
            k       <= '0;
            pkt_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                cmd_r.head <= iv_cmd_head;
                // A zero-length command still produces one beat.
                cmd_r.len  <= (iv_cmd_len == '0) ? LEN_WIDTH'(1) : iv_cmd_len;
                cmd_r.seed <= iv_cmd_seed;
                k          <= '0;
            end
            if (beat_fire) begin
                if (at_last) pkt_cnt <= pkt_cnt + 32'd1;
                else         k       <= k + LEN_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        o_cmd_ready        = 1'b0;
        o_packet_out_valid = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) state_nxt = SEND;
            end
            SEND: begin
                o_packet_out_valid = 1'b1;
                if (i_packet_out_ready && at_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat base word; each lane adds its own index. Wrap-around is modulo 2^32.
    assign base = cmd_r.seed + 32'(k) * 32'(WORDS);

    for (genvar j = 0; j < WORDS; j++) begin : g_lane
        packet_stream_gen_lane #(.IDX(j)) u_lane (
            .en  (o_packet_out_valid),
            .base(base),
            .word(words[j])
        );
    end

    assign ov_packet_out_data = words;
    assign ov_packet_out_head = o_packet_out_valid ? cmd_r.head : '0;
    assign o_packet_out_start = o_packet_out_valid && (k == '0);
    assign o_packet_out_last  = o_packet_out_valid && at_last;
    assign o_busy             = (state == SEND);
    assign ov_pkt_cnt         = pkt_cnt;
endmodule

// File: tb/tb_packet_stream_gen.sv
// Directed plus randomized bench for packet_stream_gen; expected beats come from the
// payload formula seed + k*words + j evaluated per beat.
module tb_packet_stream_gen;
    localparam int HW = 512;
    localparam int PW = 512;
    localparam int LW = 16;
    localparam int WORDS = PW / 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic [HW-1:0] iv_cmd_head = '0;
    logic [LW-1:0] iv_cmd_len = '0;
    logic [31:0]   iv_cmd_seed = '0;
    logic          o_cmd_ready;
    logic          o_packet_out_valid;
    logic [HW-1:0] ov_packet_out_head;
    logic [PW-1:0] ov_packet_out_data;
    logic          o_packet_out_start;
    logic          o_packet_out_last;
    logic          i_packet_out_ready = 1'b0;
    logic          o_busy;
    logic [31:0]   ov_pkt_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt = '0;

    packet_stream_gen #(.HEADER_BUS_WIDTH(HW), .PAYLOAD_BUS_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .iv_cmd_head(iv_cmd_head), .iv_cmd_len(iv_cmd_len),
        .iv_cmd_seed(iv_cmd_seed), .o_cmd_ready(o_cmd_ready),
        .o_packet_out_valid(o_packet_out_valid), .ov_packet_out_head(ov_packet_out_head),
        .ov_packet_out_data(ov_packet_out_data), .o_packet_out_start(o_packet_out_start),
        .o_packet_out_last(o_packet_out_last), .i_packet_out_ready(i_packet_out_ready),
        .o_busy(o_busy), .ov_pkt_cnt(ov_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HW-1:0] rand_head();
        logic [HW-1:0] h;
        for (int i = 0; i < HW / 32; i++) h[32*i +: 32] = $urandom;
        return h;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, HW'(o_packet_out_valid), '0);
        chk({tag, "_cmd_ready"}, HW'(o_cmd_ready), HW'(1));
        chk({tag, "_busy"}, HW'(o_busy), '0);
        chk({tag, "_pkt_cnt"}, HW'(ov_pkt_cnt), HW'(exp_cnt));
    endtask

    task automatic issue(input logic [HW-1:0] h, input logic [LW-1:0] len, input logic [31:0] seed);
        int n = 0;
        while (!o_cmd_ready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("cmd_ready_timeout", HW'(o_cmd_ready), HW'(1));
        i_cmd_valid = 1'b1; iv_cmd_head = h; iv_cmd_len = len; iv_cmd_seed = seed;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    // Compare every visible beat (fired or held) against the model for beat index k.
    task automatic check_beat(input logic [HW-1:0] h, input int L, input logic [31:0] seed, input int k);
        logic [31:0] e;
        chk("valid", HW'(o_packet_out_valid), HW'(1));
        chk("busy", HW'(o_busy), HW'(1));
        chk("cmd_ready_in_send", HW'(o_cmd_ready), '0);
        chk("head", ov_packet_out_head, h);
        chk("start", HW'(o_packet_out_start), HW'(k == 0));
        chk("last", HW'(o_packet_out_last), HW'(k == L - 1));
        for (int j = 0; j < WORDS; j++) begin
            e = seed + 32'(k) * 32'(WORDS) + 32'(j);
            chk($sformatf("data_k%0d_w%0d", k, j), HW'(ov_packet_out_data[32*j +: 32]), HW'(e));
        end
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready.
    task automatic run_pkt(input logic [HW-1:0] h, input logic [LW-1:0] len,
                           input logic [31:0] seed, input int mode, input bit inject);
        int L = (len == 0) ? 1 : int'(len);
        int k = 0;
        int c = 0;
        logic rdy;
        issue(h, len, seed);
        while (k < L && c < 2000) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (c % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_packet_out_ready = rdy;
            check_beat(h, L, seed, k);
            if (inject && k < L - 1) begin
                i_cmd_valid = 1'b1; iv_cmd_head = rand_head(); iv_cmd_len = 5;
            end else begin
                i_cmd_valid = 1'b0;
            end
            if (rdy) k++;
            tick();
            c++;
        end
        if (c >= 2000) chk("beat_timeout", HW'(k), HW'(L));
        i_cmd_valid = 1'b0;
        i_packet_out_ready = 1'b0;
        exp_cnt++;
        check_idle("post_pkt");
    endtask

    initial begin
        // reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        chk("reset_start", HW'(o_packet_out_start), '0);
        chk("reset_last", HW'(o_packet_out_last), '0);
        chk("reset_data", HW'(ov_packet_out_data), '0);
        rst_n = 1'b1;
        tick();

        // single-beat packet, then seed wrap across a 4-beat packet
        run_pkt(rand_head(), 16'd1, 32'h0000_0010, 0, 1'b0);
        run_pkt(rand_head(), 16'd4, 32'hFFFF_FFF8, 0, 1'b0);
        // backpressure with a competing command during SEND
        run_pkt(rand_head(), 16'd3, $urandom, 1, 1'b1);
        // zero length acts as one beat
        run_pkt(rand_head(), 16'd0, $urandom, 0, 1'b0);

        // reset in the middle of an 8-beat packet
        issue(rand_head(), 16'd8, 32'h100);
        i_packet_out_ready = 1'b1;
        repeat (3) tick();
        chk("mid_k3_start", HW'(o_packet_out_start), '0);
        chk("mid_valid", HW'(o_packet_out_valid), HW'(1));
        rst_n = 1'b0;
        i_packet_out_ready = 1'b0;
        tick();
        exp_cnt = '0;
        chk("rst_mid_last", HW'(o_packet_out_last), '0);
        check_idle("rst_mid");
        rst_n = 1'b1;
        run_pkt(rand_head(), 16'd2, 32'hABCD_0000, 0, 1'b0);

        // randomized packets with random backpressure
        for (int p = 0; p < 20; p++)
            run_pkt(rand_head(), LW'($urandom_range(0, 6)), $urandom, 2, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
